vram_tile_blitter: RTL and testbench
====================================

# vram_tile_blitter

Bus-side writer for the 1 bpp 640x480 frame buffer. The display path reads VRAM port B at `y*80 + x[9:3]` and emits bit `~x[2:0]` of each byte. This block is the matching producer on VRAM port A. It takes one tile command (an 8x8 cell at column 0..79, tile row 0..59) and performs eight byte writes, one per scanline. Three ops are supported: draw, clear, and XOR via read-modify-write, so the CPU issues one command instead of eight bus stores.

## Interface
- `COLS`, 80, byte columns per scanline; scanline stride in bytes.
- `TROWS`, 60, tile rows (480/8).
- `RD_LATENCY`, 1, VRAM port-A read latency in cycles (≥1).
- `clk`  in  1  single clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `start`  in  1  command strobe, sampled only while `busy`=0.
- `op`  in  2  00 draw, 01 clear, 10 xor, 11 reserved.
- `col`  in  7  tile column 0..COLS-1.
- `trow`  in  6  tile row 0..TROWS-1.
- `glyph`  in  64  bitmap; byte k = `glyph[63-8k -: 8]`, top scanline is k=0, MSB is the leftmost pixel.
- `busy`  out  1  command in progress.
- `done`  out  1  one-cycle pulse, command completed.
- `err`  out  1  one-cycle pulse, command rejected.
- `vram_we`  out  1  port-A write enable.
- `vram_addr`  out  16  port-A byte address.
- `vram_dout`  out  8  port-A write data.
- `vram_din`  in  8  port-A read data.

## Operation
- `col`, `trow`, `op` and `glyph` are latched on acceptance. Inputs may change afterwards.
- Base address = `trow*8*COLS + col`, i.e. `trow*640 + col`. Scanline k address = base + 80k for k=0..7.
  - Maximum address is 38399.
  - Compute in 16 bits; no overflow for legal inputs.
- Rejection: `col`≥COLS, `trow`≥TROWS, or `op`=11.
  - `err` pulses in the next cycle.
  - No VRAM access occurs, `busy` stays 0 and `done` stays 0.
- States: IDLE, WRITE, READ, WAIT, RMW, FINISH.
- IDLE:
  - `start` with a legal command goes to WRITE (draw/clear) or READ (xor). Line counter k=0.
- WRITE: `vram_we`=1, `vram_addr`=base+80k.
  - `vram_dout` = glyph byte k for draw, 0x00 for clear.
  - Then k++. After k=7, go to FINISH.
- READ: `vram_we`=0, `vram_addr`=base+80k. Then go to WAIT.
- WAIT: holds address with `vram_we`=0 for RTL_LATENCY-1 cycles. With RD_LATENCY=1 the state is skipped.
- RMW: `vram_we`=1, same address, `vram_dout` = `vram_din` XOR glyph byte k.
  - Then k++ and back to READ. After k=7, go to FINISH.
- FINISH: `done`=1 for one cycle, `busy`=0, `vram_we`=0. Return to IDLE.
- All outputs are registered. `vram_addr` and `vram_dout` hold their last value when `vram_we`=0, except in READ.
- `start` while `busy`=1 is ignored: no queueing, no `err`.
- A `start` sampled in the FINISH cycle is accepted, so commands can run back-to-back.

## Timing
- Reset (async, `resetn`=0): state IDLE, k=0. All outputs are 0 immediately, with no clock required.
- Reset mid-command aborts. A partially written tile remains in VRAM; that is acceptable. No `done` or `err` is produced.
- Draw/clear: `start` sampled at edge N.
  - `busy`=1 and `vram_we`=1 in cycles N+1..N+8.
  - `done`=1 and `busy`=0 in cycle N+9.
  - Latency is 9 cycles.
- XOR with RD_LATENCY=1: READ/RMW alternate in cycles N+1..N+16, with writes in the even cycles. `done` is in cycle N+17.
- XOR in general: 8*(RD_LATENCY+1) access cycles, then `done`.
- `err` is in cycle N+1 for a rejected command.
- `vram_din` is sampled in the RMW cycle. It must reflect the address presented RD_LATENCY cycles earlier.
- Display port B contention is outside this block (true dual-port RAM).

## Test plan
- Draw, `col`=0, `trow`=0, glyph 0x7C868A92A2C27C00 → writes to addresses 0,80,…,560 with data 7C,86,8A,92,A2,C2,7C,00 in cycles N+1..N+8. `done` in N+9.
- Corner tile, `col`=79, `trow`=59, clear → eight writes of 0x00 at 37839,37919,…,38399. No address above 38399.
- XOR, preload bytes 0xFF at 645+80k, `col`=5, `trow`=1, glyph all 0x0F → each RMW writes 0xF0. `done` in N+17. Repeat with RD_LATENCY=2 → `done` in N+25, same data.
- Illegal commands: `col`=80; `trow`=60; `op`=11 → each gives an `err` pulse in N+1, `vram_we` never 1, `busy` stays 0.
- `start` pulsed at N+3 during a draw is ignored (one `done` only). `start` in the FINISH cycle starts the next command, with its first write at N+10.
- `resetn` low at N+4 of a draw → outputs 0 asynchronously. After release, a new draw completes normally with 8 writes starting at k=0.

Source files
------------

// File: rtl/vram_tile_blitter.sv
// Tile writer for the 1 bpp 640x480 frame buffer on VRAM port A.
// One command writes the eight scanline bytes of an 8x8 cell: draw, clear or XOR (read-modify-write).
module vram_tile_blitter #(
    parameter int COLS       = 80,
    parameter int TROWS      = 60,
    parameter int RD_LATENCY = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [6:0]  col,
    input  logic [5:0]  trow,
    input  logic [63:0] glyph,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        vram_we,
    output logic [15:0] vram_addr,
    output logic [7:0]  vram_dout,
    input  logic [7:0]  vram_din
);

    localparam logic [1:0] OP_CLEAR = 2'b01;
    localparam logic [1:0] OP_XOR   = 2'b10;
    localparam int         WCW      = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    // state  | meaning
    // IDLE / FINISH accept commands; WRITE stores a line; READ, WAIT fetch one for RMW to write back
    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_WAIT, S_RMW, S_FINISH} state_t;

    state_t          state_q, state_d;
    logic [2:0]      k_q, k_d;
    logic [WCW-1:0]  wcnt_q, wcnt_d;
    logic [15:0]     base_q, base_d;
    logic [63:0]     glyph_q, glyph_d;
    logic [1:0]      op_q, op_d;
    logic            busy_q, busy_d, done_q, done_d, err_q, err_d, we_q, we_d;
    logic [15:0]     addr_q, addr_d;
    logic [7:0]      dout_q, dout_d;
    logic            cmd_ok, can_start;
    logic [7:0]      rmw_data;

    function automatic logic [7:0] glyph_byte(input logic [63:0] g, input logic [2:0] k);
        return g[63 - 8*int'(k) -: 8];
    endfunction

    assign cmd_ok    = (int'(col) < COLS) && (int'(trow) < TROWS) && (op != 2'b11);
    assign can_start = (state_q == S_IDLE) || (state_q == S_FINISH);
    assign rmw_data  = vram_din ^ glyph_byte(glyph_q, k_q);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            wcnt_q  <= '0;
            base_q  <= '0;
            glyph_q <= '0;
            op_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            wcnt_q  <= wcnt_d;
            base_q  <= base_d;
            glyph_q <= glyph_d;
            op_q    <= op_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        wcnt_d  = wcnt_q;
        base_d  = base_q;
        glyph_d = glyph_q;
        op_d    = op_q;
        case (state_q)
            S_IDLE, S_FINISH: begin
                state_d = S_IDLE;
                if (start && cmd_ok) begin
                    op_d    = op;
                    glyph_d = glyph;
                    base_d  = 16'(trow) * 16'(8 * COLS) + 16'(col);
                    k_d     = '0;
                    state_d = (op == OP_XOR) ? S_READ : S_WRITE;
                end
            end
            S_WRITE: begin
                k_d = k_q + 3'd1;
                if (k_q == 3'd7) state_d = S_FINISH;
            end
            S_READ: begin
                if (RD_LATENCY > 1) begin
                    state_d = S_WAIT;
                    wcnt_d  = WCW'(RD_LATENCY - 2);
                end else begin
                    state_d = S_RMW;
                end
            end
            S_WAIT: begin
                if (wcnt_q == '0) state_d = S_RMW;
                else              wcnt_d  = wcnt_q - 1'b1;
            end
            S_RMW: begin
                k_d     = k_q + 3'd1;
                state_d = (k_q == 3'd7) ? S_FINISH : S_READ;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_comb begin
        busy_d = (state_d == S_WRITE) || (state_d == S_READ) || (state_d == S_WAIT) || (state_d == S_RMW);
        done_d = (state_d == S_FINISH);
        err_d  = can_start && start && !cmd_ok;
        we_d   = (state_d == S_WRITE) || (state_d == S_RMW);
        addr_d = addr_q;
        dout_d = dout_q;
        if (state_q == S_RMW) dout_d = rmw_data;
        if ((state_d == S_WRITE) || (state_d == S_READ)) addr_d = base_d + 16'(k_d) * 16'(COLS);
        if (state_d == S_WRITE) dout_d = (op_d == OP_CLEAR) ? 8'h00 : glyph_byte(glyph_d, k_d);
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign vram_we   = we_q;
    assign vram_addr = addr_q;
    // Read data only arrives during the RMW cycle itself, so that write path bypasses the register.
    assign vram_dout = (state_q == S_RMW) ? rmw_data : dout_q;

endmodule

// File: tb/tb_vram_tile_blitter.sv
// Directed bench for vram_tile_blitter: one instance at read latency 1, one at read latency 2.
module tb_vram_tile_blitter;

    logic        clk = 1'b0;
    logic        resetn, start1, start2;
    logic [1:0]  op;
    logic [6:0]  col;
    logic [5:0]  trow;
    logic [63:0] glyph;

    logic        busy1, done1, err1, we1, busy2, done2, err2, we2;
    logic [15:0] addr1, addr2;
    logic [7:0]  dout1, dout2, din1, din2;

    logic [7:0]  mem1 [0:65535];
    logic [7:0]  mem2 [0:65535];
    logic [7:0]  rd1, rd2a, rd2b;
    logic        pl_en;
    logic [15:0] pl_addr;
    logic [7:0]  pl_data;

    logic        sel;
    logic        obs_busy, obs_done, obs_we;
    logic [15:0] obs_addr;
    logic [7:0]  obs_dout;

    int          n_chk = 0, n_pass = 0;
    int          wr_cnt1 = 0, done_cnt1 = 0, err_cnt1 = 0;
    logic [15:0] max_addr1 = '0;

    always #5 clk = ~clk;

    vram_tile_blitter #(.COLS(80), .TROWS(60), .RD_LATENCY(1)) u_dut1 (
        .clk(clk), .resetn(resetn), .start(start1), .op(op), .col(col), .trow(trow),
        .glyph(glyph), .busy(busy1), .done(done1), .err(err1), .vram_we(we1),
        .vram_addr(addr1), .vram_dout(dout1), .vram_din(din1)
    );

    vram_tile_blitter #(.COLS(80), .TROWS(60), .RD_LATENCY(2)) u_dut2 (
        .clk(clk), .resetn(resetn), .start(start2), .op(op), .col(col), .trow(trow),
        .glyph(glyph), .busy(busy2), .done(done2), .err(err2), .vram_we(we2),
        .vram_addr(addr2), .vram_dout(dout2), .vram_din(din2)
    );

    always @(posedge clk) begin
        if (pl_en) begin
            mem1[pl_addr] <= pl_data;
            mem2[pl_addr] <= pl_data;
        end else begin
            if (we1) mem1[addr1] <= dout1;
            if (we2) mem2[addr2] <= dout2;
        end
        rd1  <= mem1[addr1];
        rd2a <= mem2[addr2];
        rd2b <= rd2a;
        if (we1) wr_cnt1 <= wr_cnt1 + 1;
        if (done1) done_cnt1 <= done_cnt1 + 1;
        if (err1) err_cnt1 <= err_cnt1 + 1;
        if (we1 && addr1 > max_addr1) max_addr1 <= addr1;
    end

    assign din1     = rd1;
    assign din2     = rd2b;
    assign obs_busy = sel ? busy2 : busy1;
    assign obs_done = sel ? done2 : done1;
    assign obs_we   = sel ? we2   : we1;
    assign obs_addr = sel ? addr2 : addr1;
    assign obs_dout = sel ? dout2 : dout1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Called at a falling edge; returns at the falling edge of cycle N+1.
    task automatic cmd(input bit which, input logic [1:0] o, input logic [6:0] c,
                       input logic [5:0] t, input logic [63:0] g);
        op = o; col = c; trow = t; glyph = g;
        if (which) start2 = 1'b1;
        else       start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic preload(input logic [15:0] base, input logic [63:0] bytes);
        for (int k = 0; k < 8; k++) begin
            pl_en   = 1'b1;
            pl_addr = base + 16'(80 * k);
            pl_data = bytes[63 - 8*k -: 8];
            @(negedge clk);
        end
        pl_en = 1'b0;
    endtask

    task automatic expect_draw(input string tag, input logic [15:0] base, input logic [63:0] data);
        logic [7:0] b;
        for (int k = 0; k < 8; k++) begin
            b = data[63 - 8*k -: 8];
            chk({tag, " write"}, {obs_busy, obs_we, obs_addr, obs_dout},
                {1'b1, 1'b1, base + 16'(80 * k), b});
            @(negedge clk);
        end
        chk({tag, " done"}, {obs_done, obs_busy, obs_we}, 3'b100);
    endtask

    task automatic expect_xor(input string tag, input int lat, input logic [15:0] base,
                              input logic [63:0] pre, input logic [63:0] g);
        logic [7:0]  b;
        logic [15:0] a;
        for (int k = 0; k < 8; k++) begin
            a = base + 16'(80 * k);
            b = pre[63 - 8*k -: 8] ^ g[63 - 8*k -: 8];
            for (int j = 0; j < lat; j++) begin
                chk({tag, " read"}, {obs_busy, obs_we, obs_addr}, {1'b1, 1'b0, a});
                @(negedge clk);
            end
            chk({tag, " rmw"}, {obs_busy, obs_we, obs_addr, obs_dout}, {1'b1, 1'b1, a, b});
            @(negedge clk);
        end
        chk({tag, " done"}, {obs_done, obs_busy, obs_we}, 3'b100);
    endtask

    task automatic reject(input string tag, input logic [1:0] o, input logic [6:0] c,
                          input logic [5:0] t);
        int w0;
        w0 = wr_cnt1;
        cmd(1'b0, o, c, t, 64'hFFFF_FFFF_FFFF_FFFF);
        chk({tag, " err pulse"}, {err1, busy1, we1, done1}, 4'b1000);
        @(negedge clk);
        chk({tag, " err clear"}, {err1, busy1, we1, done1}, 4'b0000);
        @(negedge clk);
        chk({tag, " no write"}, 64'(wr_cnt1 - w0), 64'd0);
    endtask

    initial begin
        logic [63:0] got;
        int w0, d0, e0;
        resetn = 1'b0; start1 = 1'b0; start2 = 1'b0; sel = 1'b0;
        op = '0; col = '0; trow = '0; glyph = '0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        repeat (3) @(negedge clk);
        chk("reset dut1", {busy1, done1, err1, we1, addr1, dout1}, 64'd0);
        chk("reset dut2", {busy2, done2, err2, we2, addr2, dout2}, 64'd0);
        resetn = 1'b1;
        @(negedge clk);

        cmd(1'b0, 2'b00, 7'd0, 6'd0, 64'h7C86_8A92_A2C2_7C00);
        expect_draw("draw00", 16'd0, 64'h7C86_8A92_A2C2_7C00);
        @(negedge clk);
        chk("draw00 done one cycle", obs_done, 1'b0);
        for (int k = 0; k < 8; k++) got[63 - 8*k -: 8] = mem1[80 * k];
        chk("draw00 vram", got, 64'h7C86_8A92_A2C2_7C00);

        cmd(1'b0, 2'b01, 7'd79, 6'd59, 64'hFFFF_FFFF_FFFF_FFFF);
        expect_draw("clear corner", 16'd37839, 64'd0);
        @(negedge clk);
        chk("max address", max_addr1, 16'd38399);

        preload(16'd645, {8{8'hFF}});
        cmd(1'b0, 2'b10, 7'd5, 6'd1, {8{8'h0F}});
        expect_xor("xor lat1", 1, 16'd645, {8{8'hFF}}, {8{8'h0F}});
        @(negedge clk);
        sel = 1'b1;
        cmd(1'b1, 2'b10, 7'd5, 6'd1, {8{8'h0F}});
        expect_xor("xor lat2", 2, 16'd645, {8{8'hFF}}, {8{8'h0F}});
        @(negedge clk);
        for (int k = 0; k < 8; k++) got[63 - 8*k -: 8] = mem2[645 + 80 * k];
        chk("xor lat2 vram", got, {8{8'hF0}});
        sel = 1'b0;

        preload(16'd1290, 64'hA0A1_A2A3_A4A5_A6A7);
        cmd(1'b0, 2'b10, 7'd10, 6'd2, 64'h0102_0408_1020_4080);
        expect_xor("xor mixed", 1, 16'd1290, 64'hA0A1_A2A3_A4A5_A6A7, 64'h0102_0408_1020_4080);
        @(negedge clk);
        for (int k = 0; k < 8; k++) got[63 - 8*k -: 8] = mem1[1290 + 80 * k];
        chk("xor mixed vram", got, 64'hA0A1_A2A3_A4A5_A6A7 ^ 64'h0102_0408_1020_4080);

        reject("col80", 2'b00, 7'd80, 6'd0);
        reject("trow60", 2'b00, 7'd0, 6'd60);
        reject("op11", 2'b11, 7'd0, 6'd0);

        w0 = wr_cnt1; d0 = done_cnt1; e0 = err_cnt1;
        cmd(1'b0, 2'b00, 7'd1, 6'd0, 64'h1122_3344_5566_7788);
        @(negedge clk);
        @(negedge clk);
        op = 2'b01; col = 7'd2; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (8) @(negedge clk);
        chk("ignored start done count", 64'(done_cnt1 - d0), 64'd1);
        chk("ignored start write count", 64'(wr_cnt1 - w0), 64'd8);
        chk("ignored start no err", 64'(err_cnt1 - e0), 64'd0);
        chk("ignored start held", {busy1, addr1, dout1}, {1'b0, 16'd561, 8'h88});

        cmd(1'b0, 2'b00, 7'd3, 6'd0, 64'hDEAD_BEEF_0123_4567);
        expect_draw("b2b first", 16'd3, 64'hDEAD_BEEF_0123_4567);
        cmd(1'b0, 2'b00, 7'd4, 6'd2, 64'h8877_6655_4433_2211);
        expect_draw("b2b second", 16'd1284, 64'h8877_6655_4433_2211);
        @(negedge clk);

        d0 = done_cnt1;
        cmd(1'b0, 2'b00, 7'd6, 6'd3, 64'hC3C3_A5A5_5A5A_3C3C);
        repeat (3) @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("async reset mid draw", {busy1, done1, err1, we1, addr1, dout1}, 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("no done after abort", 64'(done_cnt1 - d0), 64'd0);
        cmd(1'b0, 2'b00, 7'd6, 6'd3, 64'hC3C3_A5A5_5A5A_3C3C);
        expect_draw("draw after reset", 16'd1926, 64'hC3C3_A5A5_5A5A_3C3C);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
